// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared constants for the fetch/decode instruction buffer
package if_id_queue_pkg;

    localparam logic RST_ENABLE = 1'b1;
    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W = 32;
    localparam logic [INST_BUS_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch/decode handshake bundle for the instruction buffer
interface if_id_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int CNT_W = 3
);

    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              flush_i;
    logic              id_ready;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [CNT_W-1:0]  count;

    modport master (
        output if_valid, if_pc, if_inst, flush_i, id_ready,
        input  if_ready, id_valid, id_pc, id_inst, count
    );

    modport slave (
        input  if_valid, if_pc, if_inst, flush_i, id_ready,
        output if_ready, id_valid, id_pc, id_inst, count
    );

endinterface

// File: rtl/if_id_queue_inst_byte_swap.sv
// rtl/if_id_queue_inst_byte_swap.sv - combinational byte reversal of an instruction word
module inst_byte_swap #(
    parameter int INST_W = 32
) (
    input  logic [INST_W-1:0] inst_in,
    output logic [INST_W-1:0] inst_out
);

    localparam int NBYTES = INST_W / 8;

    generate
        for (genvar k = 0; k < NBYTES; k++) begin : g_byte
            assign inst_out[k*8 +: 8] = inst_in[(NBYTES-1-k)*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - DEPTH-entry IF/ID instruction buffer with flush and optional byte swap
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W    = INST_ADDR_BUS_W,
    parameter int INST_W    = INST_BUS_W,
    parameter int DEPTH     = 4,
    parameter bit BYTE_SWAP = 1'b1,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input logic          clk,
    input logic          rst,
    if_id_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [INST_W-1:0] wr_inst;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Swap happens on the write side so decode always sees ready-to-use words.
    generate
        if (BYTE_SWAP) begin : g_swap
            inst_byte_swap #(.INST_W(INST_W)) u_swap (
                .inst_in  (bus.if_inst),
                .inst_out (wr_inst)
            );
        end else begin : g_pass
            assign wr_inst = bus.if_inst;
        end
    endgenerate

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign push  = bus.if_valid & ~full & ~bus.flush_i;
    assign pop   = ~empty & bus.id_ready & ~bus.flush_i;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is left untouched by reset/flush; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= bus.if_pc;
            inst_mem[wr_ptr] <= wr_inst;
        end
    end

    assign bus.if_ready = ~full;
    assign bus.id_valid = ~empty;
    assign bus.count    = cnt;
    assign bus.id_pc    = empty ? ADDR_W'(ZERO_WORD) : pc_mem[rd_ptr];
    assign bus.id_inst  = empty ? INST_W'(ZERO_WORD) : inst_mem[rd_ptr];

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for the IF/ID instruction buffer
module tb_if_id_queue;

    localparam logic [31:0] BAD_PC = 32'h0000_BAD0;

    logic clk;
    logic rst;

    if_id_queue_if #(.ADDR_W(32), .INST_W(32), .CNT_W(3)) bus1 ();
    if_id_queue_if #(.ADDR_W(32), .INST_W(32), .CNT_W(3)) bus0 ();

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .BYTE_SWAP(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .BYTE_SWAP(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int          checks = 0;
    int          passes = 0;
    int          m_cnt = 0;
    int          acc_cnt = 0;
    bit          mon_en = 0;
    bit          bad_seen = 0;
    logic [31:0] cur_exp_inst = '0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];

    logic [31:0] fill_pc   [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] fill_inst [5] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h13000000};
    logic [31:0] fill_exp  [5] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD, 32'h00000013};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Reference occupancy model + scoreboard compare, evaluated away from the active edge.
    always @(negedge clk) begin
        bit push_m;
        bit pop_m;
        if (rst) begin
            m_cnt = 0;
            exp_pc_q.delete();
            exp_inst_q.delete();
        end else begin
            if (mon_en) begin
                chk("count", 64'(bus1.count), 64'(m_cnt));
                chk("if_ready", 64'(bus1.if_ready), 64'(m_cnt != 4));
                chk("id_valid", 64'(bus1.id_valid), 64'(m_cnt != 0));
                if (m_cnt == 0) begin
                    chk("bubble_pc", 64'(bus1.id_pc), 64'(0));
                    chk("bubble_inst", 64'(bus1.id_inst), 64'(0));
                end
                if (bus1.id_valid && bus1.id_pc == BAD_PC) bad_seen = 1;
            end
            push_m = bus1.if_valid && (m_cnt != 4) && !bus1.flush_i;
            pop_m  = (m_cnt != 0) && bus1.id_ready && !bus1.flush_i;
            if (bus1.flush_i) begin
                m_cnt = 0;
                exp_pc_q.delete();
                exp_inst_q.delete();
            end else begin
                if (pop_m) begin
                    if (exp_pc_q.size() == 0) begin
                        chk("pop_sb_empty", 64'(1), 64'(0));
                    end else begin
                        chk("pop_pc", 64'(bus1.id_pc), 64'(exp_pc_q[0]));
                        chk("pop_inst", 64'(bus1.id_inst), 64'(exp_inst_q[0]));
                        void'(exp_pc_q.pop_front());
                        void'(exp_inst_q.pop_front());
                    end
                end
                if (push_m) begin
                    exp_pc_q.push_back(bus1.if_pc);
                    exp_inst_q.push_back(cur_exp_inst);
                    acc_cnt++;
                end
                m_cnt = m_cnt + int'(push_m) - int'(pop_m);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exp);
        bus1.if_valid = 1'b1;
        bus1.if_pc    = pc;
        bus1.if_inst  = inst;
        cur_exp_inst  = exp;
    endtask

    task automatic wait_acc();
        int start;
        start = acc_cnt;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (acc_cnt != start) break;
        end
        if (acc_cnt == start) chk("accept_timeout", 64'(0), 64'(1));
        bus1.if_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exp);
        offer(pc, inst, exp);
        wait_acc();
    endtask

    task automatic drain();
        bus1.id_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (m_cnt == 0) break;
            cyc();
        end
        cyc();
        chk("drain_empty", 64'(bus1.id_valid), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        bus1.if_valid = 0; bus1.if_pc = '0; bus1.if_inst = '0; bus1.flush_i = 0; bus1.id_ready = 0;
        bus0.if_valid = 0; bus0.if_pc = '0; bus0.if_inst = '0; bus0.flush_i = 0; bus0.id_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", 64'(bus1.count), 64'(0));
        chk("rst_id_valid", 64'(bus1.id_valid), 64'(0));
        chk("rst_id_inst", 64'(bus1.id_inst), 64'(0));
        chk("rst_if_ready", 64'(bus1.if_ready), 64'(1));
        chk("rst0_if_ready", 64'(bus0.if_ready), 64'(1));
        mon_en = 1'b1;

        // single push with byte swap
        bus1.id_ready = 1'b1;
        send(32'h100, 32'h13000000, 32'h00000013);
        chk("single_valid", 64'(bus1.id_valid), 64'(1));
        chk("single_pc", 64'(bus1.id_pc), 64'(32'h100));
        chk("single_inst", 64'(bus1.id_inst), 64'(32'h00000013));
        cyc();
        chk("single_after", 64'(bus1.id_valid), 64'(0));

        // fill while decode stalls; fifth offer waits for a slot
        bus1.id_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(fill_pc[i], fill_inst[i], fill_exp[i]);
        offer(fill_pc[4], fill_inst[4], fill_exp[4]);
        cyc();
        cyc();
        chk("full_if_ready", 64'(bus1.if_ready), 64'(0));
        chk("full_count", 64'(bus1.count), 64'(4));
        bus1.id_ready = 1'b1;
        wait_acc();
        drain();

        // steady push+pop at occupancy 2 across pointer wrap
        bus1.id_ready = 1'b0;
        send(32'h200, 32'h00000000, 32'h00000000);
        send(32'h204, 32'h04000000, 32'h00000004);
        bus1.id_ready = 1'b1;
        for (int i = 2; i < 10; i++) begin
            logic [31:0] pc;
            pc = 32'h200 + 32'(4 * i);
            send(pc, {pc[7:0], 24'h0}, {24'h0, pc[7:0]});
        end
        chk("steady_count", 64'(bus1.count), 64'(2));
        drain();

        // flush while full with a same-cycle offer
        bus1.id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] pc;
            pc = 32'h300 + 32'(4 * i);
            send(pc, {pc[7:0], 24'hA5A5A5}, {24'hA5A5A5, pc[7:0]});
        end
        offer(BAD_PC, 32'hDEADBEEF, 32'hEFBEADDE);
        bus1.flush_i = 1'b1;
        cyc();
        bus1.flush_i = 1'b0;
        bus1.if_valid = 1'b0;
        chk("flush_count", 64'(bus1.count), 64'(0));
        chk("flush_id_inst", 64'(bus1.id_inst), 64'(0));
        chk("flush_id_valid", 64'(bus1.id_valid), 64'(0));
        bus1.id_ready = 1'b1;
        repeat (3) cyc();

        // reset at occupancy 3 while decode is ready
        bus1.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pc;
            pc = 32'h400 + 32'(4 * i);
            send(pc, {pc[7:0], 24'h0}, {24'h0, pc[7:0]});
        end
        chk("pre_rst_count", 64'(bus1.count), 64'(3));
        bus1.id_ready = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_count", 64'(bus1.count), 64'(0));
        chk("midrst_id_valid", 64'(bus1.id_valid), 64'(0));
        cyc();
        chk("midrst_still_empty", 64'(bus1.id_valid), 64'(0));

        // pass-through build
        bus0.if_valid = 1'b1;
        bus0.if_pc    = 32'h100;
        bus0.if_inst  = 32'h13000000;
        bus0.id_ready = 1'b1;
        cyc();
        bus0.if_valid = 1'b0;
        chk("noswap_valid", 64'(bus0.id_valid), 64'(1));
        chk("noswap_pc", 64'(bus0.id_pc), 64'(32'h100));
        chk("noswap_inst", 64'(bus0.id_inst), 64'(32'h13000000));
        cyc();
        chk("noswap_after", 64'(bus0.id_valid), 64'(0));

        chk("flushed_pc_never_seen", 64'(bad_seen), 64'(0));
        chk("sb_empty_at_end", 64'(exp_pc_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Sits between the fetch stage and decode as a DEPTH-entry instruction buffer with a valid/ready handshake on both sides, a flush input and optional endian byte-swap.
- Decouples fetch from decode stalls so memory-side fetch can run ahead. Presents a zero (bubble) instruction to decode when empty or flushed.

Parameters:
- ADDR_W, 32: PC width.
- INST_W, 32: instruction width; must be a multiple of 8.
- DEPTH, 4: number of buffer entries; power of two, minimum 2.
- BYTE_SWAP, 1: 1 = byte-reverse if_inst on write (little-endian memory to decode order); 0 = pass through unchanged.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width (derived).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset (RstEnable = 1'b1).
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_pc  in  ADDR_W  PC of the offered instruction.
- if_inst  in  INST_W  raw instruction word from fetch.
- if_ready  out  1  buffer can accept; equals (count != DEPTH).
- flush_i  in  1  discard all buffered and incoming entries (branch/jump redirect).
- id_ready  in  1  decode consumes the head entry this cycle; 0 = decode stall.
- id_valid  out  1  head entry valid; equals (count != 0).
- id_pc  out  ADDR_W  PC of the head entry; ZeroWord when id_valid = 0.
- id_inst  out  INST_W  instruction of the head entry, already swapped; ZeroWord (bubble) when id_valid = 0.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x (ADDR_W + INST_W) register array, plus write pointer wr_ptr, read pointer rd_ptr (each log2(DEPTH) bits) and count.
- Push = if_valid & if_ready & ~flush_i. Pop = id_valid & id_ready & ~flush_i.
- Push writes the entry at wr_ptr. With BYTE_SWAP = 1, byte k of the stored word = byte (INST_W/8-1-k) of if_inst.
- Pointers increment modulo DEPTH; wrap from DEPTH-1 to 0 is natural.
- Count update: push only = +1; pop only = -1; push and pop together = unchanged.
- Latency: an entry pushed at edge N appears on id_* after edge N, i.e. one cycle. There is no same-cycle combinational bypass when empty.
- id_pc and id_inst are driven from the head entry, muxed to ZeroWord when empty. Their values are independent of id_ready in the current cycle.
- Full: if_ready = 0, so a push is refused even if a pop occurs in the same cycle (no pass-through when full). Fetch must hold if_pc/if_inst until accepted.
- Empty: id_valid = 0 and id_* = 0. Any id_ready is ignored.
- Flush (priority over push and pop): at the next edge wr_ptr = rd_ptr = count = 0. Any same-cycle if_valid entry is dropped. Storage contents need not be cleared.
- Reset: rst = 1 at an edge has the same effect as flush, taking priority over everything. After reset, count = 0, id_valid = 0, id_pc = id_inst = 0, if_ready = 1.
- Reset or flush arriving mid-stream with the buffer full returns it to empty in exactly one cycle. No partial drain.
- No other state machine. State is fully described by the pointers and count.

Decomposition:
- Shared package (define.v): RstEnable, ZeroWord, InstAddrBus/InstBus widths, NOP encoding.
- One natural sub-module: inst_byte_swap, a combinational parametrised byte reversal (INST_W) reused by the fetch path. It is instantiated only when BYTE_SWAP = 1, via a generate block.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles, then 0 -> count = 0, id_valid = 0, id_inst = 0, if_ready = 1.
- Single push, byte swap: push pc = 0x100, inst = 0x13000000 (BYTE_SWAP = 1), id_ready = 1 -> next cycle id_valid = 1, id_pc = 0x100, id_inst = 0x00000013; following cycle empty.
- Fill and stall: id_ready = 0; push 5 instructions at pc 0x0, 0x4, ... -> first 4 accepted, if_ready = 0 with count = 4. Releasing id_ready pops 0x0, 0x4, 0x8, 0xC in order; the 5th is accepted once count = 3.
- Simultaneous push and pop at count = 2: count stays 2, head advances by one, wr_ptr wraps 3 -> 0 correctly over 8 continuous cycles.
- Flush with buffer full plus if_valid in the same cycle -> next cycle count = 0, id_inst = 0, and the incoming pc is never presented.
- rst asserted while count = 3 with id_ready = 1 -> next cycle empty, no pop observed; BYTE_SWAP = 0 build re-run of the single-push test gives id_inst = 0x13000000.
